// File: rtl/riscv_mem_pkg.sv
// Shared memory-system constants for the pipeline, the debug loader and the data RAM arbiter.
// Reserved MMIO addresses live here so upstream decode and the loader agree on them.
package riscv_mem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int NUM_PORTS   = 2;

  localparam int PORT_PIPE = 0;
  localparam int PORT_DBG  = 1;

  localparam logic [31:0] SWITCH_ADDR = 32'h10;
  localparam logic [31:0] LED_ADDR    = 32'h14;

  function automatic logic word_aligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_age_counter.sv
// Saturating count of consecutive cycles the low-priority port was refused;
// raises force_grant once the refusal streak reaches MAX_WAIT.
module dmem_age_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic force_grant
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!req || gnt) begin
      cnt_next = '0;
    end else if (cnt_reg < CNT_W'(MAX_WAIT)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force_grant = (cnt_reg >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: pipeline port wins by
// default, the debug/loader port is force-granted after MAX_WAIT refusals.
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] we;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] aligned;
  logic [NUM_PORTS-1:0] rvalid;
  logic [NUM_PORTS-1:0] err_reg;
  logic [31:0]          addr           [NUM_PORTS];
  logic [31:0]          wdata          [NUM_PORTS];
  logic [31:0]          rdata          [NUM_PORTS];
  logic [31:0]          rdata_hold_reg [NUM_PORTS];

  logic force1;
  logic sel_port;
  logic any_gnt;
  logic rsp_valid_reg;
  logic rsp_port_reg;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign addr[PORT_PIPE]  = m0_addr;
  assign addr[PORT_DBG]   = m1_addr;
  assign wdata[PORT_PIPE] = m0_wdata;
  assign wdata[PORT_DBG]  = m1_wdata;

  dmem_age_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (4)
  ) u_age (
    .clk         (clk),
    .rst         (rst),
    .req         (m1_req),
    .gnt         (gnt[PORT_DBG]),
    .force_grant (force1)
  );

  // Requests seen while rst is high are ignored, so grants are gated by reset.
  assign gnt[PORT_DBG]  = !rst && req[PORT_DBG] && (force1 || !req[PORT_PIPE]);
  assign gnt[PORT_PIPE] = !rst && req[PORT_PIPE] && !gnt[PORT_DBG];

  assign sel_port = gnt[PORT_DBG];
  assign any_gnt  = |gnt;

  assign mem_en    = any_gnt && aligned[sel_port];
  assign mem_we    = mem_en && we[sel_port];
  assign mem_addr  = any_gnt ? addr[sel_port][ADDR_W+1:2] : '0;
  assign mem_wdata = any_gnt ? wdata[sel_port] : '0;

  // Only reads produce a response; rst also drops one already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_port_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= mem_en && !mem_we;
      rsp_port_reg  <= sel_port;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign aligned[gi] = word_aligned(addr[gi]);
      assign rvalid[gi]  = !rst && rsp_valid_reg && (rsp_port_reg == 1'(gi));
      assign rdata[gi]   = rst ? 32'h0 : (rvalid[gi] ? mem_rdata : rdata_hold_reg[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_hold_reg[gi] <= 32'h0;
          err_reg[gi]        <= 1'b0;
        end else begin
          if (rvalid[gi]) begin
            rdata_hold_reg[gi] <= mem_rdata;
          end
          err_reg[gi] <= gnt[gi] && !aligned[gi];
        end
      end
    end
  endgenerate

  assign m0_gnt    = gnt[PORT_PIPE];
  assign m0_rvalid = rvalid[PORT_PIPE];
  assign m0_rdata  = rdata[PORT_PIPE];
  assign m0_err    = !rst && err_reg[PORT_PIPE];

  assign m1_gnt    = gnt[PORT_DBG];
  assign m1_rvalid = rvalid[PORT_DBG];
  assign m1_rdata  = rdata[PORT_DBG];
  assign m1_err    = !rst && err_reg[PORT_DBG];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m1_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM
// (registered read, write at the enable edge) attached to the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram [1024];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
  endtask

  // Advance to the next cycle's drive point (negedge), then let inputs settle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    idle();
    rst = 1;

    // Reset with requests present: nothing is granted
    next_cycle();
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h80;
    settle();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_m0_rdata", m0_rdata, 0);

    // Test 1: read granted, then reset drops the response
    next_cycle();
    rst = 0; idle(); m0_req = 1; m0_addr = 32'h40;
    settle();
    chk("t1_m0_gnt", m0_gnt, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    next_cycle();
    rst = 1; idle();
    settle();
    chk("t1_rst_rvalid", m0_rvalid, 0);
    chk("t1_rst_mem_en", mem_en, 0);
    next_cycle();
    rst = 0;
    settle();
    chk("t1_post_rvalid", m0_rvalid, 0);
    chk("t1_post_err", m0_err, 0);
    chk("t1_wait_cnt", dut.u_age.cnt_reg, 0);

    // Test 2: port 0 write then read-after-write
    next_cycle();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hDEADBEEF;
    settle();
    chk("t2_wr_gnt", m0_gnt, 1);
    chk("t2_wr_mem_we", mem_we, 1);
    chk("t2_wr_mem_addr", mem_addr, 32'h10);
    next_cycle();
    m0_we = 0; m0_wdata = 0;
    settle();
    chk("t2_rd_gnt", m0_gnt, 1);
    chk("t2_rd_mem_we", mem_we, 0);
    chk("t2_rd_mem_en", mem_en, 1);
    next_cycle();
    idle();
    settle();
    chk("t2_rvalid", m0_rvalid, 1);
    chk("t2_rdata", m0_rdata, 32'hDEADBEEF);
    next_cycle();
    settle();
    chk("t2_rvalid_drop", m0_rvalid, 0);
    chk("t2_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Preload 0x80 for the contention read
    next_cycle();
    m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'hCAFEF00D;
    settle();
    chk("t3_pre_gnt", m0_gnt, 1);

    // Test 3: m0 hogs the RAM, m1 forced in on the fifth cycle
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_wdata = 0;
      m1_req = 1; m1_we = 0; m1_addr = 32'h80;
      settle();
      chk($sformatf("t3_c%0d_m1_gnt", c), m1_gnt, 0);
      chk($sformatf("t3_c%0d_m0_gnt", c), m0_gnt, 1);
    end
    next_cycle();
    settle();
    chk("t3_c5_m1_gnt", m1_gnt, 1);
    chk("t3_c5_m0_gnt", m0_gnt, 0);
    chk("t3_c5_mem_addr", mem_addr, 32'h20);
    chk("t3_c5_wait_cnt", dut.u_age.cnt_reg, 4);
    next_cycle();
    idle();
    settle();
    chk("t3_m1_rvalid", m1_rvalid, 1);
    chk("t3_m1_rdata", m1_rdata, 32'hCAFEF00D);
    chk("t3_m0_rvalid", m0_rvalid, 0);
    chk("t3_wait_cnt", dut.u_age.cnt_reg, 0);

    // Test 4: m1 burst of writes with port 0 idle
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      m1_req = 1; m1_we = 1; m1_addr = 32'(4 * k); m1_wdata = 32'(17 * (k + 1));
      settle();
      chk($sformatf("t4_w%0d_gnt", k), m1_gnt, 1);
      chk($sformatf("t4_w%0d_mem_we", k), mem_we, 1);
      chk($sformatf("t4_w%0d_mem_addr", k), mem_addr, 32'(k));
      chk($sformatf("t4_w%0d_mem_wdata", k), mem_wdata, 32'(17 * (k + 1)));
    end
    next_cycle();
    idle();
    settle();
    chk("t4_no_rvalid", m1_rvalid, 0);

    // Test 5: misaligned read on port 0
    next_cycle();
    m0_req = 1; m0_addr = 32'h42;
    settle();
    chk("t5_gnt", m0_gnt, 1);
    chk("t5_mem_en", mem_en, 0);
    next_cycle();
    idle();
    settle();
    chk("t5_err", m0_err, 1);
    chk("t5_rvalid", m0_rvalid, 0);
    next_cycle();
    settle();
    chk("t5_err_drop", m0_err, 0);

    // Test 6: back-to-back reads from the two ports
    next_cycle();
    m1_req = 1; m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'h12345678;
    settle();
    chk("t6_pre_gnt", m1_gnt, 1);
    next_cycle();
    idle();
    m0_req = 1; m0_addr = 32'h40;
    settle();
    chk("t6_m0_gnt", m0_gnt, 1);
    next_cycle();
    idle();
    m1_req = 1; m1_addr = 32'h44;
    settle();
    chk("t6_m1_gnt", m1_gnt, 1);
    chk("t6_m0_rvalid", m0_rvalid, 1);
    chk("t6_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t6_m1_rvalid_early", m1_rvalid, 0);
    chk("t6_m1_rdata_hold", m1_rdata, 32'hCAFEF00D);
    next_cycle();
    idle();
    settle();
    chk("t6_m1_rvalid", m1_rvalid, 1);
    chk("t6_m1_rdata", m1_rdata, 32'h12345678);
    chk("t6_m0_rvalid_drop", m0_rvalid, 0);
    chk("t6_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
